// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling,
// whole-scan debounce and linear key index output with a press strobe.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8,
  localparam int KW      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] col_drive,
  output logic [KW-1:0]   key,
  output logic            key_valid,
  output logic            key_down,
  output logic            multi
);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CIW = $clog2(COLS);
  localparam int CW  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, RELEASE_PEND} state_t;

  logic [ROWS-1:0] rows_s1, rows_s2;
  logic [DW-1:0]   dwell;
  logic [CIW-1:0]  col;
  logic [1:0]      acc_n;
  logic [KW-1:0]   acc_key;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   cand;

  logic [1:0]      col_n, tot_n;
  logic [2:0]      sum_n;
  logic [KW-1:0]   col_key, scan_key;
  logic            sample, scan_end;

  // Lowest active row wins, so iterate downward and let the last hit stick.
  always_comb begin
    col_n   = '0;
    col_key = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (rows_s2[r]) col_key = KW'(r * COLS) + KW'(col);
    for (int r = 0; r < ROWS; r++)
      if (rows_s2[r] && col_n != 2'd2) col_n = col_n + 2'd1;
    sum_n    = {1'b0, acc_n} + {1'b0, col_n};
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    scan_key = (acc_n != 2'd0) ? acc_key : col_key;
    sample   = (dwell == DW'(SCAN_DIV - 1));
    scan_end = sample && (col == CIW'(COLS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_s1   <= '0;
      rows_s2   <= '0;
      dwell     <= '0;
      col       <= '0;
      col_drive <= COLS'(1);
      acc_n     <= '0;
      acc_key   <= '0;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi     <= 1'b0;
    end else begin
      rows_s1   <= rows;
      rows_s2   <= rows_s1;
      key_valid <= 1'b0;
      if (!sample) begin
        dwell <= dwell + DW'(1);
      end else begin
        dwell     <= '0;
        col_drive <= {col_drive[COLS-2:0], col_drive[COLS-1]};
        col       <= scan_end ? '0 : col + CIW'(1);
        if (!scan_end) begin
          acc_n <= tot_n;
          if (acc_n == 2'd0 && col_n != 2'd0) acc_key <= col_key;
        end else begin
          acc_n   <= '0;
          acc_key <= '0;
          multi   <= (tot_n == 2'd2);
          case (state)
            IDLE:
              if (tot_n == 2'd1) begin
                cand <= scan_key;
                if (DEBOUNCE == 1) begin
                  state     <= HELD;
                  key       <= scan_key;
                  key_valid <= 1'b1;
                  key_down  <= 1'b1;
                  cnt       <= '0;
                end else begin
                  state <= PRESS_PEND;
                  cnt   <= CW'(1);
                end
              end
            PRESS_PEND:
              if (tot_n == 2'd1 && scan_key == cand) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                  state     <= HELD;
                  key       <= cand;
                  key_valid <= 1'b1;
                  key_down  <= 1'b1;
                  cnt       <= '0;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end else if (tot_n == 2'd1) begin
                cand <= scan_key;
                cnt  <= CW'(1);
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            HELD:
              if (tot_n == 2'd0) begin
                if (DEBOUNCE == 1) begin
                  state    <= IDLE;
                  key_down <= 1'b0;
                  cnt      <= '0;
                end else begin
                  state <= RELEASE_PEND;
                  cnt   <= CW'(1);
                end
              end
            RELEASE_PEND:
              if (tot_n == 2'd0) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                  state    <= IDLE;
                  key_down <= 1'b0;
                  cnt      <= '0;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end else begin
                state <= HELD;
                cnt   <= '0;
              end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x4 pad, 4-clock dwell, 3-scan debounce.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] col_drive;
  logic [3:0] key;
  logic       key_valid, key_down, multi;
  logic [15:0] pressed = '0;

  int errs = 0;
  int nchk = 0;
  int pulses = 0;
  int p0;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .rows(rows), .col_drive(col_drive),
    .key(key), .key_valid(key_valid), .key_down(key_down), .multi(multi)
  );

  always #5 clk = ~clk;

  // Pad model: a pressed key connects its driven column onto its row.
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col_drive[c]) rows[r] = 1'b1;
  end

  always @(negedge clk) if (key_valid) pulses <= pulses + 1;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench #1 into cycle 0 of the first scan.
  task automatic do_reset();
    reset = 1'b1;
    clocks(2);
    reset = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_key"}, key, 0);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_down"}, key_down, 0);
    chk({tag, "_multi"}, multi, 0);
  endtask

  initial begin
    // Column walk with no keys.
    pressed = '0;
    do_reset();
    chk_idle_outs("rst");
    for (int t = 0; t < 20; t++) begin
      chk("coldrv", col_drive, 1 << ((t / 4) % 4));
      clocks(1);
    end
    chk_idle_outs("idle");

    // Steady key 6: accepted at end of scan 3, then no repeats.
    pressed = 16'h0040;
    do_reset();
    p0 = pulses;
    clocks(32);
    chk("k6_pend_down", key_down, 0);
    chk("k6_pend_pulses", pulses - p0, 0);
    clocks(16);
    chk("k6_valid", key_valid, 1);
    chk("k6_key", key, 6);
    chk("k6_down", key_down, 1);
    clocks(1);
    chk("k6_valid_1clk", key_valid, 0);
    clocks(15 + 160);
    chk("k6_hold_pulses", pulses - p0, 1);
    chk("k6_hold_down", key_down, 1);
    chk("k6_hold_key", key, 6);

    // Two-scan press then release: rejected.
    pressed = 16'h0040;
    do_reset();
    p0 = pulses;
    clocks(32);
    pressed = '0;
    clocks(64);
    chk("short_pulses", pulses - p0, 0);
    chk("short_down", key_down, 0);
    chk("short_key", key, 0);

    // Keys 6 and 9 together, then 9 released.
    pressed = 16'h0240;
    do_reset();
    p0 = pulses;
    clocks(16);
    chk("multi_set", multi, 1);
    chk("multi_valid", key_valid, 0);
    clocks(32);
    chk("multi_pulses", pulses - p0, 0);
    chk("multi_down", key_down, 0);
    pressed = 16'h0040;
    clocks(16);
    chk("multi_clr", multi, 0);
    chk("multi_clr_down", key_down, 0);
    clocks(32);
    chk("after_multi_valid", key_valid, 1);
    chk("after_multi_key", key, 6);

    // Release debounce and a single-scan bounce while held.
    pressed = 16'h0040;
    do_reset();
    clocks(48);
    chk("rel_acc_down", key_down, 1);
    pressed = '0;
    clocks(32);
    chk("rel_pend_down", key_down, 1);
    clocks(16);
    chk("rel_down", key_down, 0);
    chk("rel_key_kept", key, 6);
    pressed = 16'h0040;
    p0 = pulses;
    clocks(48);
    chk("repress_valid", key_valid, 1);
    clocks(16);
    chk("repress_pulses", pulses - p0, 1);
    p0 = pulses;
    pressed = '0;
    clocks(16);
    chk("bounce_down_gap", key_down, 1);
    pressed = 16'h0040;
    clocks(48);
    chk("bounce_down", key_down, 1);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_key", key, 6);

    // Reset during PRESS_PEND aborts the press.
    pressed = 16'h0040;
    do_reset();
    p0 = pulses;
    clocks(32);
    reset = 1'b1;
    clocks(1);
    reset = 1'b0;
    chk("midrst_col", col_drive, 1);
    chk_idle_outs("midrst");
    clocks(32);
    chk("midrst_pend_down", key_down, 0);
    chk("midrst_pend_pulses", pulses - p0, 0);
    clocks(16);
    chk("midrst_valid", key_valid, 1);
    chk("midrst_key", key, 6);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner and debouncer. Drives the keypad columns one at a time and samples the rows through an internal synchroniser. Debounces the result over whole scans and emits a linear key index with a one-cycle `key_valid` strobe per accepted press. Sits between the keypad pins and downstream consumers; any legend mapping (e.g. the 4x4 hex layout) is a separate LUT stage downstream.

## Interface
- `ROWS`, 4, number of keypad rows (>=1)
- `COLS`, 4, number of keypad columns (>=2)
- `SCAN_DIV`, 1000, clocks each column is driven (dwell); must be >=4
- `DEBOUNCE`, 8, consecutive identical scan results required to accept a press or release (>=1)
- `KW`, derived, $clog2(ROWS*COLS), minimum 1; width of `key`
- `clk`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `rows`  in  ROWS  raw row inputs, active-high, asynchronous to `clk`
- `col_drive`  out  COLS  one-hot active-high column drive
- `key`  out  KW  index of last accepted key = row*COLS + col
- `key_valid`  out  1  one-cycle pulse when a new press is accepted
- `key_down`  out  1  level: accepted key currently held
- `multi`  out  1  level: most recent completed scan saw >=2 active keys

## Operation
- Reset values: `col_drive`=one-hot bit 0, `key`=0, `key_valid`=0, `key_down`=0, `multi`=0. FSM=IDLE, dwell counter=0, debounce counter=0, scan accumulators cleared, synchroniser flops=0.
- Rows pass through a 2-flop synchroniser. All sampling uses the synchronised value.
- Dwell counter runs 0..SCAN_DIV-1 per column.
  - On count SCAN_DIV-1: sample synchronised rows for the current column, then advance `col_drive` one bit.
  - Column COLS-1 wraps to 0.
- Per-scan accumulation over columns 0..COLS-1:
  - Count active keys, saturating at 2.
  - Record the first active key, scanning lowest column first, then lowest row.
- Scan end occurs at the sample of column COLS-1. The scan result is NONE (0 keys), SINGLE(c) (exactly 1 key, index c) or MULTI (>=2). Accumulators clear for the next scan.
- `multi` updates at every scan end to (result==MULTI).
- Debounce FSM, evaluated only at scan end; `cnt` is the debounce counter:
  - IDLE:
    - SINGLE(c) -> PRESS_PEND, cand=c, cnt=1. If DEBOUNCE==1, go directly to the HELD acceptance actions.
    - NONE or MULTI -> stay.
  - PRESS_PEND:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE: -> HELD, `key`<=cand, `key_valid` pulse, `key_down`<=1.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - HELD:
    - NONE -> RELEASE_PEND, cnt=1. If DEBOUNCE==1, go directly to IDLE with `key_down`<=0.
    - SINGLE(any) or MULTI -> stay; `key` unchanged, no pulse.
  - RELEASE_PEND:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE: -> IDLE, `key_down`<=0.
    - Any non-NONE -> HELD, cnt=0.
- `key` holds its value after release. It changes only on acceptance.
- Reset asserted mid-scan or mid-debounce aborts everything and restores the reset values on the next edge. No `key_valid` is emitted for an interrupted press.

## Timing
- Scan period: COLS*SCAN_DIV clocks.
- Synchroniser latency: 2 clocks. SCAN_DIV>=4 guarantees the rows settle within the dwell.
- `key_valid` and `key_down` rise in the same cycle: the clock after the scan-end sample of the DEBOUNCE-th consecutive SINGLE(c) scan. `key` updates in that same cycle.
- `key_valid` is high for exactly 1 clock. At most one pulse per press/release cycle.
- `key_down` falls the clock after the scan-end sample of the DEBOUNCE-th consecutive NONE scan.
- `multi` updates the clock after each scan-end sample.
- First scan after reset starts at column 0, dwell count 0.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, giving a 16-clock scan.
- Reset, rows=0 -> `col_drive` 0001, 0010, 0100, 1000, each for 4 clocks, then back to 0001. All other outputs stay 0.
- Hold row1/col2 steady (rows=4'b0010 while `col_drive`=4'b0100) -> after the 3rd complete scan: `key`=6, `key_valid` one pulse, `key_down`=1. No further pulses across 10 more scans.
- Same key held for 2 scans, then released -> no `key_valid`, `key_down` stays 0, `key` stays 0.
- Hold key 6 and key 9 (row2/col1) together -> `multi`=1 after the first scan end, no `key_valid`. Then release key 9 -> `multi`=0, and `key_valid` with `key`=6 after 3 further scans.
- Accept key 6, then release -> `key_down` falls after 3 empty scans. One bounce (one NONE scan between held scans) keeps `key_down`=1 with no new pulse.
- Assert `reset` for 1 clock during PRESS_PEND (after 2 matching scans) -> outputs return to reset values. A fresh 3-scan hold is required before `key_valid`.
